queue_counter: RTL

- Upstream stage of the wait-time lookup. Converts two raw photocell beams (queue entry, teller exit) into a stable, bounded people count `pCount`.
- Also outputs a sanitised teller count `tCount`, so the downstream lookup always gets pCount in 0..7 and tCount in 1..3.
- Holds the count in registers and handles sensor debounce, simultaneous entry/exit, and full/empty saturation.

---
 rtl/queue_counter_pkg.sv | 23 ++
 rtl/queue_counter_if.sv | 32 +++
 rtl/queue_counter_sensor_debounce.sv | 83 ++++++++
 rtl/queue_counter.sv | 103 ++++++++++
 4 files changed

// File: rtl/queue_counter_pkg.sv
// rtl/queue_counter_pkg.sv - shared widths, debounce state encodings and helpers for queue_counter
package queue_counter_pkg;

    localparam int PCOUNT_W      = 3;
    localparam int TCOUNT_W      = 2;
    localparam int DEB_CNT_W     = 4;
    localparam int MAX_COUNT_DEF = 7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUAL    = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    typedef struct packed {
        logic inc;
        logic dec;
    } cnt_evt_t;

    // A zero teller count would underflow the downstream lookup, so it reads as one.
    function automatic logic [TCOUNT_W-1:0] clamp_tellers(input logic [TCOUNT_W-1:0] t);
        return (t == '0) ? TCOUNT_W'(1) : t;
    endfunction

endpackage

// File: rtl/queue_counter_if.sv
// rtl/queue_counter_if.sv - sensor inputs and count outputs of queue_counter; err exists with QUEUE_COUNTER_ERR_EN
interface queue_counter_if;
    import queue_counter_pkg::*;

    logic                front;
    logic                back;
    logic [TCOUNT_W-1:0] tellers;
    logic [PCOUNT_W-1:0] pCount;
    logic [TCOUNT_W-1:0] tCount;
    logic                empty;
    logic                full;
`ifdef QUEUE_COUNTER_ERR_EN
    logic                err;
`endif

    modport master (
        output front, back, tellers,
        input  pCount, tCount, empty, full
`ifdef QUEUE_COUNTER_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  front, back, tellers,
        output pCount, tCount, empty, full
`ifdef QUEUE_COUNTER_ERR_EN
        , output err
`endif
    );

endinterface

// File: rtl/queue_counter_sensor_debounce.sv
// rtl/queue_counter_sensor_debounce.sv - 2-flop synchroniser and debounce FSM; one-cycle pass pulse on beam release
module sensor_debounce
    import queue_counter_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pass
);

    localparam logic [DEB_CNT_W-1:0] DEB_TGT = DEB_CNT_W'(DEBOUNCE);
    localparam logic [DEB_CNT_W-1:0] CNT_ONE = DEB_CNT_W'(1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [DEB_CNT_W-1:0] cnt_q;
    logic [DEB_CNT_W-1:0] cnt_d;
    logic [DEB_CNT_W-1:0] cnt_inc;
    logic                 pass_q;
    logic                 pass_d;

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    cnt_d   = CNT_ONE;
                    state_d = (DEB_TGT == CNT_ONE) ? ST_BLOCKED : ST_QUAL;
                end
            end
            ST_QUAL: begin
                if (sync2_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_TGT) begin
                        state_d = ST_BLOCKED;
                    end
                end else begin
                    // Beam restored before qualification: a glitch, nothing is reported.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_BLOCKED: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pass_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign pass = pass_q;

endmodule

// File: rtl/queue_counter.sv
// rtl/queue_counter.sv - debounced, saturating people counter with clamped teller count; QUEUE_COUNTER_ERR_EN adds sticky err
module queue_counter
    import queue_counter_pkg::*;
#(
    parameter int DEBOUNCE  = 4,
    parameter int MAX_COUNT = MAX_COUNT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    queue_counter_if.slave  bus
);

    localparam logic [PCOUNT_W-1:0] MAX_P = PCOUNT_W'(MAX_COUNT);
    localparam logic [PCOUNT_W-1:0] ONE_P = PCOUNT_W'(1);

    cnt_evt_t            evt;
    logic [PCOUNT_W-1:0] pcount_q;
    logic [PCOUNT_W-1:0] pcount_d;
    logic                empty_q;
    logic                full_q;
    logic [TCOUNT_W-1:0] tel_sync1_q;
    logic [TCOUNT_W-1:0] tel_sync2_q;
    logic [TCOUNT_W-1:0] tcount_q;
    logic                ignored;

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_front (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.front),
        .pass (evt.inc)
    );

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_back (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.back),
        .pass (evt.dec)
    );

    // Simultaneous entry and exit cancel out, even at either boundary.
    always_comb begin
        pcount_d = pcount_q;
        ignored  = 1'b0;
        if (evt.inc && !evt.dec) begin
            if (pcount_q != MAX_P) begin
                pcount_d = pcount_q + ONE_P;
            end else begin
                ignored = 1'b1;
            end
        end else if (evt.dec && !evt.inc) begin
            if (pcount_q != '0) begin
                pcount_d = pcount_q - ONE_P;
            end else begin
                ignored = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcount_q    <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            tel_sync1_q <= '0;
            tel_sync2_q <= '0;
            tcount_q    <= TCOUNT_W'(1);
        end else begin
            pcount_q    <= pcount_d;
            empty_q     <= (pcount_d == '0);
            full_q      <= (pcount_d == MAX_P);
            tel_sync1_q <= bus.tellers;
            tel_sync2_q <= tel_sync1_q;
            tcount_q    <= clamp_tellers(tel_sync2_q);
        end
    end

    assign bus.pCount = pcount_q;
    assign bus.tCount = tcount_q;
    assign bus.empty  = empty_q;
    assign bus.full   = full_q;

`ifdef QUEUE_COUNTER_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (ignored) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_ignored;
    assign unused_ignored = ignored;
`endif

endmodule
